// File: rtl/rvc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_pkg
//  Description : Shared RV32 opcode / RVC field constants and register helper
//  Revision    : 1.0 - initial release
// ============================================================================
package rvc_pkg;

   // 32-bit base opcodes produced by the expander
   localparam logic [6:0] c_OP_IMM = 7'b0010011;
   localparam logic [6:0] c_LUI    = 7'b0110111;
   localparam logic [6:0] c_LOAD   = 7'b0000011;
   localparam logic [6:0] c_STORE  = 7'b0100011;
   localparam logic [6:0] c_JAL    = 7'b1101111;
   localparam logic [6:0] c_JALR   = 7'b1100111;
   localparam logic [6:0] c_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP     = 7'b0110011;
   localparam logic [6:0] c_SYSTEM = 7'b1110011;

   // Compressed quadrants
   localparam logic [1:0] c_Q0 = 2'b00;
   localparam logic [1:0] c_Q1 = 2'b01;
   localparam logic [1:0] c_Q2 = 2'b10;

   // Compressed funct3 codes
   localparam logic [2:0] c_F3_000 = 3'b000;
   localparam logic [2:0] c_F3_001 = 3'b001;
   localparam logic [2:0] c_F3_010 = 3'b010;
   localparam logic [2:0] c_F3_011 = 3'b011;
   localparam logic [2:0] c_F3_100 = 3'b100;
   localparam logic [2:0] c_F3_101 = 3'b101;
   localparam logic [2:0] c_F3_110 = 3'b110;
   localparam logic [2:0] c_F3_111 = 3'b111;

   // Three-bit compressed register field addresses x8..x15
   function automatic logic [4:0] creg(input logic [2:0] i_r);
      return {2'b01, i_r};
   endfunction

endpackage
`default_nettype wire

// File: rtl/rvc_expand.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_expand
//  Description : Combinational RV32C 16-bit to 32-bit instruction expander
//  Revision    : 1.0 - initial release
// ============================================================================
module rvc_expand
   import rvc_pkg::*;
#(
   parameter int C_EN = 1
)(
   input  logic [15:0] I_instr,
   output logic [31:0] O_data,
   output logic        O_illegal
);

   logic [15:0] w_c;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rdp;
   logic [4:0]  w_rs1p;
   logic [20:0] w_joff;
   logic [12:0] w_boff;
   logic [31:0] w_data;
   logic        w_ill;

   assign w_c    = I_instr;
   assign w_rd   = w_c[11:7];
   assign w_rs2  = w_c[6:2];
   assign w_rdp  = creg(w_c[4:2]);
   assign w_rs1p = creg(w_c[9:7]);

   assign w_joff = {{10{w_c[12]}}, w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2],
                    w_c[11], w_c[5:3], 1'b0};
   assign w_boff = {{5{w_c[12]}}, w_c[6:5], w_c[2], w_c[11:10], w_c[4:3], 1'b0};

   always_comb begin
      w_data = '0;
      w_ill  = 1'b0;
      case (w_c[1:0])
         c_Q0: begin
            case (w_c[15:13])
               c_F3_000: begin
                  w_data = {2'b00, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b00,
                            5'd2, 3'b000, w_rdp, c_OP_IMM};
                  w_ill  = (w_c[12:5] == 8'd0);
               end
               c_F3_010: w_data = {5'b0, w_c[5], w_c[12:10], w_c[6], 2'b00,
                                   w_rs1p, 3'b010, w_rdp, c_LOAD};
               c_F3_110: w_data = {5'b0, w_c[5], w_c[12], w_rdp, w_rs1p, 3'b010,
                                   w_c[11:10], w_c[6], 2'b00, c_STORE};
               default:  w_ill  = 1'b1;
            endcase
         end
         c_Q1: begin
            case (w_c[15:13])
               c_F3_000: w_data = {{7{w_c[12]}}, w_c[6:2], w_rd, 3'b000, w_rd, c_OP_IMM};
               c_F3_001: w_data = {w_joff[20], w_joff[10:1], w_joff[11], w_joff[19:12],
                                   5'd1, c_JAL};
               c_F3_010: w_data = {{7{w_c[12]}}, w_c[6:2], 5'd0, 3'b000, w_rd, c_OP_IMM};
               c_F3_011: begin
                  w_ill = ({w_c[12], w_c[6:2]} == 6'd0);
                  if (w_rd == 5'd2)
                     w_data = {{3{w_c[12]}}, w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0000,
                               5'd2, 3'b000, 5'd2, c_OP_IMM};
                  else
                     w_data = {{15{w_c[12]}}, w_c[6:2], w_rd, c_LUI};
               end
               c_F3_100: begin
                  case (w_c[11:10])
                     2'b00: begin
                        w_data = {7'b0000000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, c_OP_IMM};
                        w_ill  = w_c[12];
                     end
                     2'b01: begin
                        w_data = {7'b0100000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, c_OP_IMM};
                        w_ill  = w_c[12];
                     end
                     2'b10: w_data = {{7{w_c[12]}}, w_c[6:2], w_rs1p, 3'b111, w_rs1p, c_OP_IMM};
                     default: begin
                        // c[12]=1 selects the RV64-only SUBW/ADDW group
                        if (w_c[12]) begin
                           w_ill = 1'b1;
                        end else begin
                           case (w_c[6:5])
                              2'b00:   w_data = {7'b0100000, w_rdp, w_rs1p, 3'b000, w_rs1p, c_OP};
                              2'b01:   w_data = {7'b0000000, w_rdp, w_rs1p, 3'b100, w_rs1p, c_OP};
                              2'b10:   w_data = {7'b0000000, w_rdp, w_rs1p, 3'b110, w_rs1p, c_OP};
                              default: w_data = {7'b0000000, w_rdp, w_rs1p, 3'b111, w_rs1p, c_OP};
                           endcase
                        end
                     end
                  endcase
               end
               c_F3_101: w_data = {w_joff[20], w_joff[10:1], w_joff[11], w_joff[19:12],
                                   5'd0, c_JAL};
               c_F3_110: w_data = {w_boff[12], w_boff[10:5], 5'd0, w_rs1p, 3'b000,
                                   w_boff[4:1], w_boff[11], c_BRANCH};
               default:  w_data = {w_boff[12], w_boff[10:5], 5'd0, w_rs1p, 3'b001,
                                   w_boff[4:1], w_boff[11], c_BRANCH};
            endcase
         end
         c_Q2: begin
            case (w_c[15:13])
               c_F3_000: begin
                  w_data = {7'b0000000, w_c[6:2], w_rd, 3'b001, w_rd, c_OP_IMM};
                  w_ill  = w_c[12];
               end
               c_F3_010: w_data = {4'b0000, w_c[3:2], w_c[12], w_c[6:4], 2'b00,
                                   5'd2, 3'b010, w_rd, c_LOAD};
               c_F3_100: begin
                  if (!w_c[12]) begin
                     if (w_rs2 == 5'd0) begin
                        w_data = {12'd0, w_rd, 3'b000, 5'd0, c_JALR};
                        w_ill  = (w_rd == 5'd0);
                     end else begin
                        w_data = {7'b0000000, w_rs2, 5'd0, 3'b000, w_rd, c_OP};
                     end
                  end else if (w_rs2 == 5'd0) begin
                     if (w_rd == 5'd0)
                        w_data = {12'd1, 5'd0, 3'b000, 5'd0, c_SYSTEM};
                     else
                        w_data = {12'd0, w_rd, 3'b000, 5'd1, c_JALR};
                  end else begin
                     w_data = {7'b0000000, w_rs2, w_rd, 3'b000, w_rd, c_OP};
                  end
               end
               c_F3_110: w_data = {4'b0000, w_c[8:7], w_c[12], w_rs2, 5'd2, 3'b010,
                                   w_c[11:9], 2'b00, c_STORE};
               default:  w_ill  = 1'b1;
            endcase
         end
         default: w_ill = 1'b1;
      endcase
      if (w_ill || (C_EN == 0)) begin
         w_data = '0;
         w_ill  = 1'b1;
      end
   end

   assign O_data    = w_data;
   assign O_illegal = w_ill;

endmodule
`default_nettype wire

// File: rtl/rvc_fetch_align.sv
`default_nettype none
// ============================================================================
//  Module      : rvc_fetch_align
//  Description : Halfword fetch buffer, instruction re-aligner and RVC expander
//  Revision    : 1.0 - initial release
// ============================================================================
module rvc_fetch_align
   import rvc_pkg::*;
#(
   parameter int          BUF_HW   = 4,
   parameter int          C_EN     = 1,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_flush,
   input  logic [31:0] I_flushpc,
   input  logic        I_fvalid,
   input  logic [31:0] I_fdata,
   output logic        O_fready,
   output logic        O_valid,
   input  logic        I_ready,
   output logic [31:0] O_data,
   output logic [31:0] O_pc,
   output logic [31:0] O_pcincr,
   output logic        O_illegal
);

   localparam int            PW      = $clog2(BUF_HW);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] c_DEPTH = CW'(BUF_HW);

   logic [15:0]   r_buf [BUF_HW];
   logic [PW-1:0] r_rptr;
   logic [PW-1:0] r_wptr;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_pc;
   logic          r_droplow;

   logic [15:0]   w_hd0;
   logic [15:0]   w_hd1;
   logic          w_is32;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_free;
   logic [CW-1:0] w_add;
   logic [CW-1:0] w_sub;
   logic [PW-1:0] w_wstep;
   logic [PW-1:0] w_rstep;
   logic [31:0]   w_xdata;
   logic          w_xill;
   logic          w_unused;

   assign w_unused = I_flushpc[0];

   assign w_hd0   = r_buf[r_rptr];
   assign w_hd1   = r_buf[r_rptr + PW'(1)];
   assign w_is32  = (w_hd0[1:0] == 2'b11);
   assign w_free  = c_DEPTH - r_cnt;

   assign O_fready = (w_free >= CW'(2));
   assign O_valid  = w_is32 ? (r_cnt >= CW'(2)) : (r_cnt != '0);

   assign w_push  = I_fvalid & O_fready;
   assign w_pop   = O_valid & I_ready;
   assign w_wstep = r_droplow ? PW'(1) : PW'(2);
   assign w_rstep = w_is32 ? PW'(2) : PW'(1);
   assign w_add   = w_push ? (r_droplow ? CW'(1) : CW'(2)) : '0;
   assign w_sub   = w_pop ? (w_is32 ? CW'(2) : CW'(1)) : '0;

   rvc_expand #(
      .C_EN      (C_EN)
   ) u_expand (
      .I_instr   (w_hd0),
      .O_data    (w_xdata),
      .O_illegal (w_xill)
   );

   // Outputs read as zero whenever nothing is presented, including in reset
   assign O_data    = !O_valid ? 32'd0 : (w_is32 ? {w_hd1, w_hd0} : w_xdata);
   assign O_pcincr  = !O_valid ? 32'd0 : (w_is32 ? 32'd4 : 32'd2);
   assign O_illegal = O_valid & ~w_is32 & w_xill;
   assign O_pc      = r_pc;

   always_ff @(posedge I_clk) begin
      if (w_push && !I_flush) begin
         if (r_droplow) begin
            r_buf[r_wptr] <= I_fdata[31:16];
         end else begin
            r_buf[r_wptr]          <= I_fdata[15:0];
            r_buf[r_wptr + PW'(1)] <= I_fdata[31:16];
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_rptr    <= '0;
         r_wptr    <= '0;
         r_cnt     <= '0;
         r_pc      <= RESET_PC;
         r_droplow <= RESET_PC[1];
      end else if (I_flush) begin
         r_rptr    <= '0;
         r_wptr    <= '0;
         r_cnt     <= '0;
         r_pc      <= {I_flushpc[31:1], 1'b0};
         r_droplow <= I_flushpc[1];
      end else begin
         if (w_push) begin
            r_wptr    <= r_wptr + w_wstep;
            r_droplow <= 1'b0;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + w_rstep;
            r_pc   <= r_pc + O_pcincr;
         end
         r_cnt <= r_cnt + w_add - w_sub;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rvc_fetch_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rvc_fetch_align
//  Description : Directed scoreboard bench for rvc_fetch_align
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rvc_fetch_align;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] pc;
      logic [31:0] inc;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] flushpc;
   logic        fvalid;
   logic [31:0] fdata;
   logic        fready;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic [31:0] pc;
   logic [31:0] pcincr;
   logic        illegal;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   rvc_fetch_align #(
      .BUF_HW    (4),
      .C_EN      (1),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .I_clk     (clk),
      .I_rst_n   (rst_n),
      .I_flush   (flush),
      .I_flushpc (flushpc),
      .I_fvalid  (fvalid),
      .I_fdata   (fdata),
      .O_fready  (fready),
      .O_valid   (valid),
      .I_ready   (ready),
      .O_data    (data),
      .O_pc      (pc),
      .O_pcincr  (pcincr),
      .O_illegal (illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic expect_instr(input logic [31:0] d, input logic [31:0] p,
                               input logic [31:0] inc, input logic ill);
      exp_t e;
      e.d = d; e.pc = p; e.inc = inc; e.ill = ill;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      int n;
      n      = 0;
      fvalid = 1'b1;
      fdata  = w;
      @(negedge clk);
      while (!fready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!fready) chk("push_timeout_fready", {31'd0, fready}, 32'd1);
      @(posedge clk);
      #1;
      fvalid = 1'b0;
   endtask

   task automatic do_flush(input logic [31:0] target);
      flush   = 1'b1;
      flushpc = target;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", {31'd0, valid}, 32'd0);
      chk("flush_pc", pc, {target[31:1], 1'b0});
      @(posedge clk);
      #1;
   endtask

   // Monitor: every handshake must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_issue: got data=%h pc=%h incr=%h ill=%0d expected nothing",
                        data, pc, pcincr, illegal);
            end else begin
               e = exp_q.pop_front();
               if (data === e.d && pc === e.pc && pcincr === e.inc && illegal === e.ill)
                  n_pass++;
               else
                  $display("FAIL issue@%h: got data=%h pc=%h incr=%h ill=%0d expected data=%h pc=%h incr=%h ill=%0d",
                           e.pc, data, pc, pcincr, illegal, e.d, e.pc, e.inc, e.ill);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      flushpc = 32'd0;
      fvalid  = 1'b0;
      fdata   = 32'd0;
      ready   = 1'b1;

      #12;
      chk("rst_valid",   {31'd0, valid},   32'd0);
      chk("rst_fready",  {31'd0, fready},  32'd1);
      chk("rst_pc",      pc,               32'd0);
      chk("rst_data",    data,             32'd0);
      chk("rst_pcincr",  pcincr,           32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // C.NOP then an all-zero halfword
      expect_instr(32'h0000_0013, 32'h0, 32'd2, 1'b0);
      expect_instr(32'h0000_0000, 32'h2, 32'd2, 1'b1);
      push(32'h0000_0001);
      @(negedge clk);
      chk("latency_valid", {31'd0, valid}, 32'd1);
      idle(3);

      // C.SLLI hint on x0 then all-zero halfword
      expect_instr(32'h0000_1013, 32'h4, 32'd2, 1'b0);
      expect_instr(32'h0000_0000, 32'h6, 32'd2, 1'b1);
      push(32'h0000_0002);
      idle(4);

      // C.LI followed by a 32-bit instruction straddling two words
      do_flush(32'h0000_0000);
      expect_instr(32'h0050_0513, 32'h0, 32'd2, 1'b0);
      expect_instr(32'h0050_0513, 32'h2, 32'd4, 1'b0);
      expect_instr(32'h0000_0000, 32'h6, 32'd2, 1'b1);
      push(32'h0513_4515);
      idle(3);
      @(negedge clk);
      chk("straddle_stall_valid", {31'd0, valid}, 32'd0);
      @(posedge clk);
      #1;
      push(32'h0000_0050);
      idle(4);

      // Redirect to a halfword-aligned target: low half of first word dropped
      do_flush(32'h0000_0102);
      expect_instr(32'h0050_0513, 32'h102, 32'd2, 1'b0);
      push(32'h4515_0001);
      expect_instr(32'h0000_0013, 32'h104, 32'd2, 1'b0);
      expect_instr(32'h0000_0013, 32'h106, 32'd2, 1'b0);
      push(32'h0001_0001);
      idle(4);

      // Backpressure: fill the buffer with decode stalled
      ready = 1'b0;
      expect_instr(32'h00a0_0093, 32'h108, 32'd4, 1'b0);
      expect_instr(32'h0010_0513, 32'h10c, 32'd2, 1'b0);
      expect_instr(32'h0010_0593, 32'h10e, 32'd2, 1'b0);
      expect_instr(32'h0020_81b3, 32'h110, 32'd4, 1'b0);
      expect_instr(32'h0010_0073, 32'h114, 32'd2, 1'b0);
      expect_instr(32'h0000_8067, 32'h116, 32'd2, 1'b0);
      push(32'h00a0_0093);
      push(32'h4585_4505);
      @(negedge clk);
      chk("full_fready", {31'd0, fready}, 32'd0);
      chk("stall_valid", {31'd0, valid},  32'd1);
      chk("stall_data",  data,            32'h00a0_0093);
      @(negedge clk);
      chk("stall_hold_data", data, 32'h00a0_0093);
      chk("stall_hold_pc",   pc,   32'h0000_0108);
      @(posedge clk);
      #1;
      fork
         begin
            push(32'h0020_81b3);
            push(32'h8082_9002);
         end
         begin
            repeat (3) @(negedge clk);
            chk("held_fready", {31'd0, fready}, 32'd0);
            @(posedge clk);
            #1;
            ready = 1'b1;
         end
      join
      idle(8);

      // C.ADDI4SPN and C.BEQZ
      expect_instr(32'h0041_0413, 32'h118, 32'd2, 1'b0);
      expect_instr(32'h0004_0163, 32'h11a, 32'd2, 1'b0);
      push(32'hc009_0040);
      idle(4);
      chk("end_pc", pc, 32'h0000_011c);

      // Asynchronous reset with data in the buffer
      ready = 1'b0;
      push(32'h0001_0001);
      @(negedge clk);
      chk("pre_rst_valid", {31'd0, valid}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid",  {31'd0, valid},  32'd0);
      chk("async_rst_pc",     pc,              32'd0);
      chk("async_rst_fready", {31'd0, fready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_empty", {31'd0, valid}, 32'd0);
      @(posedge clk);
      #1;
      expect_instr(32'h0000_0013, 32'h0, 32'd2, 1'b0);
      expect_instr(32'h0000_0000, 32'h2, 32'd2, 1'b1);
      push(32'h0000_0001);
      idle(4);

      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
